// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg : opcodes, FSM state encodings and control-field codes for the
//          multicycle control unit.             Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cu_pkg;

   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLL  = 6'b011000;
   localparam logic [5:0] OP_SLT  = 6'b100110;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JR   = 6'b111001;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] PCSRC_SEQ    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JR     = 2'b10;
   localparam logic [1:0] PCSRC_JUMP   = 2'b11;

   localparam logic [1:0] REGDST_RA = 2'b00;
   localparam logic [1:0] REGDST_RT = 2'b01;
   localparam logic [1:0] REGDST_RD = 2'b10;

   function automatic logic is_jump_op(input logic [5:0] op);
      return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
   endfunction

   function automatic logic is_legal_op(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT,
         OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_output_decode.sv
// ---------------------------------------------------------------------------
// cu_output_decode : combinational state + opcode -> control vector.
// Macro CU_ILLEGAL_TRAP_EN: unlisted opcodes stall instead of acting as NOP.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cu_output_decode
   import cu_pkg::*;
(
   input  logic [2:0] state,
   input  logic [5:0] opcode,
   input  logic       zero,
   output logic       IRWre,
   output logic       PCWre,
   output logic       RegWre,
   output logic       mRD,
   output logic       mWR,
   output logic       ALUSrcB,
   output logic       ExtSel,
   output logic       DBDataSrc,
   output logic [1:0] RegDst,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUOp
);

   always_comb begin
      IRWre  = 1'b0;
      PCWre  = 1'b0;
      RegWre = 1'b0;
      mRD    = 1'b0;
      mWR    = 1'b0;
      case (state)
         S_IF: IRWre = 1'b1;
         S_ID: begin
            if (is_jump_op(opcode)) PCWre = 1'b1;
            if (opcode == OP_JAL)   RegWre = 1'b1;
`ifndef CU_ILLEGAL_TRAP_EN
            // Unlisted opcodes retire here as a NOP, falling through to PC+4.
            if (!is_legal_op(opcode)) PCWre = 1'b1;
`endif
         end
         S_EXE_BR: PCWre = 1'b1;
         S_MEM: begin
            if (opcode == OP_SW) begin
               PCWre = 1'b1;
               mWR   = 1'b1;
            end
            if (opcode == OP_LW) mRD = 1'b1;
         end
         S_WB_AL, S_WB_LD: begin
            PCWre  = 1'b1;
            RegWre = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      ALUSrcB   = (opcode == OP_ADDI) || (opcode == OP_ORI) ||
                  (opcode == OP_LW)   || (opcode == OP_SW);
      ExtSel    = (opcode != OP_ORI);
      DBDataSrc = (opcode == OP_LW);

      case (opcode)
         OP_JAL:                RegDst = REGDST_RA;
         OP_ADDI, OP_ORI, OP_LW: RegDst = REGDST_RT;
         default:               RegDst = REGDST_RD;
      endcase

      case (opcode)
         OP_BEQ:    PCSrc = (state == S_EXE_BR && zero) ? PCSRC_BRANCH : PCSRC_SEQ;
         OP_JR:     PCSrc = PCSRC_JR;
         OP_J, OP_JAL: PCSrc = PCSRC_JUMP;
         default:   PCSrc = PCSRC_SEQ;
      endcase

      case (opcode)
         OP_SUB, OP_BEQ: ALUOp = ALU_SUB;
         OP_OR, OP_ORI:  ALUOp = ALU_OR;
         OP_AND:         ALUOp = ALU_AND;
         OP_SLL:         ALUOp = ALU_SLL;
         OP_SLT:         ALUOp = ALU_SLT;
         default:        ALUOp = ALU_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit : IF/ID/EXE/MEM/WB sequencer with halt latch.
// Macro CU_ILLEGAL_TRAP_EN: unlisted opcodes halt in ID.        Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int OP_W = 6,
   parameter int ST_W = 3
)(
   input  logic            CLK,
   input  logic            Reset,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero,
   output logic [ST_W-1:0] state,
   output logic            IRWre,
   output logic            PCWre,
   output logic            RegWre,
   output logic            mRD,
   output logic            mWR,
   output logic            ALUSrcB,
   output logic            ExtSel,
   output logic            DBDataSrc,
   output logic [1:0]      RegDst,
   output logic [1:0]      PCSrc,
   output logic [2:0]      ALUOp,
   output logic            halted
);

   state_t state_q, state_d;
   logic   halted_q, halted_d;

   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            if (halted_q)                 state_d = S_ID;
            else if (is_jump_op(opcode))  state_d = S_IF;
            else if (opcode == OP_HALT) begin
               state_d  = S_ID;
               halted_d = 1'b1;
            end
            else if (opcode == OP_BEQ)    state_d = S_EXE_BR;
            else if (opcode == OP_SW || opcode == OP_LW) state_d = S_EXE_LS;
            else if (is_legal_op(opcode)) state_d = S_EXE_AL;
            else begin
`ifdef CU_ILLEGAL_TRAP_EN
               state_d  = S_ID;
               halted_d = 1'b1;
`else
               state_d  = S_IF;
`endif
            end
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_WB_AL:  state_d = S_IF;
         S_EXE_BR: state_d = S_IF;
         S_EXE_LS: state_d = S_MEM;
         S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
         S_WB_LD:  state_d = S_IF;
         default:  state_d = S_IF;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q  <= S_IF;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   assign state  = state_q;
   assign halted = halted_q;

   cu_output_decode u_decode (
      .state     (state_q),
      .opcode    (opcode),
      .zero      (zero),
      .IRWre     (IRWre),
      .PCWre     (PCWre),
      .RegWre    (RegWre),
      .mRD       (mRD),
      .mWR       (mWR),
      .ALUSrcB   (ALUSrcB),
      .ExtSel    (ExtSel),
      .DBDataSrc (DBDataSrc),
      .RegDst    (RegDst),
      .PCSrc     (PCSrc),
      .ALUOp     (ALUOp)
   );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit : random instruction stream checked against a
// per-instruction trace model.                                  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control_unit;

   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010,
                          OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010,
                          SLL = 6'b011000, SLT = 6'b100110, SW = 6'b110000,
                          LW = 6'b110001, BEQ = 6'b110100, J = 6'b111000,
                          JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111,
                          ILL = 6'b101010;

   logic       CLK = 1'b0;
   logic       Reset;
   logic [5:0] opcode;
   logic       zero;
   logic [2:0] state;
   logic       IRWre, PCWre, RegWre, mRD, mWR, ALUSrcB, ExtSel, DBDataSrc, halted;
   logic [1:0] RegDst, PCSrc;
   logic [2:0] ALUOp;

   int n_checks = 0;
   int n_fail   = 0;

   multicycle_control_unit dut (
      .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .state(state),
      .IRWre(IRWre), .PCWre(PCWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
      .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .DBDataSrc(DBDataSrc),
      .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp), .halted(halted)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (op=%b t=%0t)", tag, got, exp, opcode, $time);
      end
   endtask

   typedef struct {
      logic [2:0] st;
      logic ir, pc, rw, rd, wr;
   } step_t;

   function automatic step_t mk(input logic [2:0] st, input logic ir, input logic pc,
                                input logic rw, input logic rd, input logic wr);
      step_t s;
      s.st = st; s.ir = ir; s.pc = pc; s.rw = rw; s.rd = rd; s.wr = wr;
      return s;
   endfunction

   function automatic logic is_listed(input logic [5:0] op);
      logic [5:0] tbl [15] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT,
                               SW, LW, BEQ, J, JR, JAL, HALT};
      foreach (tbl[i]) if (tbl[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Check the opcode-derived selects, plus PCSrc whenever the PC is updated.
   task automatic check_selects(input logic [5:0] op, input logic pc_upd);
      logic [1:0] rdst, psrc;
      logic [2:0] aop;
      rdst = (op == JAL) ? 2'd0 : (op == ADDI || op == ORI || op == LW) ? 2'd1 : 2'd2;
      aop  = (op == SUB || op == BEQ) ? 3'd1 : (op == OR_ || op == ORI) ? 3'd2 :
             (op == AND_) ? 3'd3 : (op == SLL) ? 3'd4 : (op == SLT) ? 3'd5 : 3'd0;
      psrc = (op == BEQ) ? {1'b0, zero} : (op == JR) ? 2'd2 :
             (op == J || op == JAL) ? 2'd3 : 2'd0;
      chk("ALUSrcB", ALUSrcB, (op == ADDI || op == ORI || op == LW || op == SW));
      chk("ExtSel", ExtSel, (op != ORI));
      chk("DBDataSrc", DBDataSrc, (op == LW));
      chk("RegDst", RegDst, rdst);
      chk("ALUOp", ALUOp, aop);
      if (pc_upd) chk("PCSrc", PCSrc, psrc);
   endtask

   // Expected cycle-by-cycle trace of one complete instruction.
   task automatic run_instr(input logic [5:0] op);
      step_t q[$];
      q.push_back(mk(3'b000, 1, 0, 0, 0, 0));
      if (op == J || op == JR || op == JAL)
         q.push_back(mk(3'b001, 0, 1, op == JAL, 0, 0));
      else if (op == BEQ) begin
         q.push_back(mk(3'b001, 0, 0, 0, 0, 0));
         q.push_back(mk(3'b101, 0, 1, 0, 0, 0));
      end else if (op == LW) begin
         q.push_back(mk(3'b001, 0, 0, 0, 0, 0));
         q.push_back(mk(3'b010, 0, 0, 0, 0, 0));
         q.push_back(mk(3'b011, 0, 0, 0, 1, 0));
         q.push_back(mk(3'b100, 0, 1, 1, 0, 0));
      end else if (op == SW) begin
         q.push_back(mk(3'b001, 0, 0, 0, 0, 0));
         q.push_back(mk(3'b010, 0, 0, 0, 0, 0));
         q.push_back(mk(3'b011, 0, 1, 0, 0, 1));
      end else if (is_listed(op)) begin
         q.push_back(mk(3'b001, 0, 0, 0, 0, 0));
         q.push_back(mk(3'b110, 0, 0, 0, 0, 0));
         q.push_back(mk(3'b111, 0, 1, 1, 0, 0));
      end else
         q.push_back(mk(3'b001, 0, 1, 0, 0, 0));

      opcode = op;
      foreach (q[i]) begin
         zero = 1'($urandom_range(0, 1));
         @(negedge CLK);
         chk("state", state, q[i].st);
         chk("IRWre", IRWre, q[i].ir);
         chk("PCWre", PCWre, q[i].pc);
         chk("RegWre", RegWre, q[i].rw);
         chk("mRD", mRD, q[i].rd);
         chk("mWR", mWR, q[i].wr);
         chk("halted", halted, 1'b0);
         check_selects(op, q[i].pc);
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic apply_reset();
      Reset = 1'b0;
      #1;
      chk("rst_state", state, 3'b000);
      chk("rst_halted", halted, 1'b0);
      chk("rst_IRWre", IRWre, 1'b1);
      chk("rst_RegWre", RegWre, 1'b0);
      chk("rst_PCWre", PCWre, 1'b0);
      chk("rst_mWR", mWR, 1'b0);
      @(posedge CLK);
      #1;
      Reset = 1'b1;
   endtask

   task automatic expect_stuck(input string tag, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(posedge CLK);
         #1;
         chk({tag, "_state"}, state, 3'b001);
         chk({tag, "_halted"}, halted, 1'b1);
         chk({tag, "_PCWre"}, PCWre, 1'b0);
         chk({tag, "_IRWre"}, IRWre, 1'b0);
         chk({tag, "_wr"}, {RegWre, mWR, mRD}, 3'b000);
      end
   endtask

`ifdef CU_ILLEGAL_TRAP_EN
   logic [5:0] pool [14] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT,
                             SW, LW, BEQ, J, JR, JAL};
`else
   logic [5:0] pool [16] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT,
                             SW, LW, BEQ, J, JR, JAL, ILL, 6'b001111};
`endif

   initial begin
      Reset  = 1'b0;
      opcode = ADD;
      zero   = 1'b0;
      @(posedge CLK);
      #1;
      apply_reset();

      run_instr(ADD);
      run_instr(LW);
      zero = 1'b1;
      run_instr(BEQ);
      run_instr(JAL);

      for (int n = 0; n < 80; n++)
         run_instr(pool[$urandom_range(0, $size(pool) - 1)]);

      // Asynchronous reset arriving in the middle of a write-back cycle.
      opcode = ADD;
      repeat (3) begin
         @(posedge CLK);
         #1;
      end
      chk("mid_wb_state", state, 3'b111);
      chk("mid_wb_RegWre", RegWre, 1'b1);
      @(negedge CLK);
      apply_reset();
      run_instr(SW);

      opcode = HALT;
      @(posedge CLK);
      #1;
      chk("halt_id_state", state, 3'b001);
      chk("halt_id_PCWre", PCWre, 1'b0);
      chk("halt_id_halted", halted, 1'b0);
      expect_stuck("halt", 10);
      apply_reset();

`ifdef CU_ILLEGAL_TRAP_EN
      opcode = ILL;
      @(posedge CLK);
      #1;
      chk("ill_id_PCWre", PCWre, 1'b0);
      expect_stuck("ill", 4);
      apply_reset();
`else
      run_instr(ILL);
`endif
      run_instr(ORI);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
